lieat_exu_com_csrfile: RTL and testbench

- Parametrised machine-mode CSR file for the EXU commit stage.
- Holds mstatus, mtvec, mepc, mcause and mscratch; optionally also the 64-bit mcycle/minstret counters.
- Executes Zicsr read/write/set/clear, hardware trap entry and mret return, with fixed priority between them.
- Provides a second, independent read port to the IFU for trap and return redirects.

---
 rtl/lieat_exu_com_csrfile.sv | 159 +++++++++++++++
 tb/tb_lieat_exu_com_csrfile.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_exu_com_csrfile.sv
// Machine-mode CSR file for the EXU commit stage: Zicsr access, trap entry, mret, IFU redirect read port.
// Define LIEAT_CSR_COUNTER_EN to build the 64-bit mcycle/minstret counters.
module lieat_exu_com_csrfile #(
  parameter int              XLEN      = 32,
  parameter int              CSR_IDX   = 12,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               csr_ena,
  input  logic [1:0]         csr_op,
  input  logic [CSR_IDX-1:0] csr_idx,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_ilgl,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [XLEN-1:0]    trap_cause,
  input  logic               mret_valid,
  input  logic               instret,
  input  logic               ifu_csr_ren,
  input  logic [CSR_IDX-1:0] ifu_csr_idx,
  output logic [XLEN-1:0]    ifu_csr_rdata,
  output logic               mstatus_mie
);

  localparam logic [CSR_IDX-1:0] A_MSTATUS  = CSR_IDX'(12'h300);
  localparam logic [CSR_IDX-1:0] A_MTVEC    = CSR_IDX'(12'h305);
  localparam logic [CSR_IDX-1:0] A_MSCRATCH = CSR_IDX'(12'h340);
  localparam logic [CSR_IDX-1:0] A_MEPC     = CSR_IDX'(12'h341);
  localparam logic [CSR_IDX-1:0] A_MCAUSE   = CSR_IDX'(12'h342);
`ifdef LIEAT_CSR_COUNTER_EN
  localparam logic [CSR_IDX-1:0] A_MCYCLE    = CSR_IDX'(12'hB00);
  localparam logic [CSR_IDX-1:0] A_MINSTRET  = CSR_IDX'(12'hB02);
  localparam logic [CSR_IDX-1:0] A_MCYCLEH   = CSR_IDX'(12'hB80);
  localparam logic [CSR_IDX-1:0] A_MINSTRETH = CSR_IDX'(12'hB82);
`endif

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mepc, mcause, mscratch;
  logic [XLEN-1:0] mstatus_rd, old_val, wval;
  logic            hit, do_wr;

`ifdef LIEAT_CSR_COUNTER_EN
  logic [63:0] mcycle, minstret, mcycle_nxt, minstret_nxt;
`endif

  // mstatus keeps only MIE/MPIE as state; MPP is hardwired to machine mode
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie;
    mstatus_rd[3]     = mie;
  end

  always_comb begin
    hit     = 1'b1;
    old_val = '0;
    case (csr_idx)
      A_MSTATUS:  old_val = mstatus_rd;
      A_MTVEC:    old_val = mtvec;
      A_MSCRATCH: old_val = mscratch;
      A_MEPC:     old_val = mepc;
      A_MCAUSE:   old_val = mcause;
`ifdef LIEAT_CSR_COUNTER_EN
      A_MCYCLE:    old_val = mcycle[XLEN-1:0];
      A_MINSTRET:  old_val = minstret[XLEN-1:0];
      A_MCYCLEH:   if (XLEN == 32) old_val = XLEN'(mcycle >> 32);   else hit = 1'b0;
      A_MINSTRETH: if (XLEN == 32) old_val = XLEN'(minstret >> 32); else hit = 1'b0;
`endif
      default:    hit = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = old_val | csr_wdata;
      2'b11:   wval = old_val & ~csr_wdata;
      default: wval = old_val;
    endcase
  end

  // trap and mret outrank any CSR write in the same cycle
  assign do_wr     = csr_ena & hit & (csr_op != 2'b00) & ~trap_valid & ~mret_valid;
  assign csr_rdata = (csr_ena & hit & ~reset) ? old_val : '0;
  assign csr_ilgl  = csr_ena & ~hit & ~reset;
  assign mstatus_mie = mie;

  always_comb begin
    ifu_csr_rdata = '0;
    if (ifu_csr_ren & ~reset) begin
      if (ifu_csr_idx == A_MTVEC)     ifu_csr_rdata = mtvec;
      else if (ifu_csr_idx == A_MEPC) ifu_csr_rdata = mepc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= {MTVEC_RST[XLEN-1:2], 2'b00};
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
    end else if (trap_valid) begin
      mepc   <= {trap_pc[XLEN-1:1], 1'b0};
      mcause <= trap_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_valid) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (do_wr) begin
      case (csr_idx)
        A_MSTATUS: begin
          mie  <= wval[3];
          mpie <= wval[7];
        end
        A_MTVEC:    mtvec    <= {wval[XLEN-1:2], 2'b00};
        A_MEPC:     mepc     <= {wval[XLEN-1:1], 1'b0};
        A_MCAUSE:   mcause   <= wval;
        A_MSCRATCH: mscratch <= wval;
        default:    ;
      endcase
    end
  end

`ifdef LIEAT_CSR_COUNTER_EN
  // a write to either half replaces that counter's increment for the cycle
  always_comb begin
    mcycle_nxt   = mcycle + 64'd1;
    minstret_nxt = minstret + 64'(instret);
    if (do_wr) begin
      case (csr_idx)
        A_MCYCLE:    mcycle_nxt   = (XLEN == 32) ? {mcycle[63:32], wval[31:0]} : 64'(wval);
        A_MCYCLEH:   mcycle_nxt   = {wval[31:0], mcycle[31:0]};
        A_MINSTRET:  minstret_nxt = (XLEN == 32) ? {minstret[63:32], wval[31:0]} : 64'(wval);
        A_MINSTRETH: minstret_nxt = {wval[31:0], minstret[31:0]};
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
    end
  end
`else
  logic unused_instret;
  assign unused_instret = instret;
`endif

endmodule

// File: tb/tb_lieat_exu_com_csrfile.sv
// Randomized self-checking bench for lieat_exu_com_csrfile against an architectural CSR model.
// Counter checks are compiled in when LIEAT_CSR_COUNTER_EN is defined.
module tb_lieat_exu_com_csrfile;
  localparam int          XLEN = 32;
  localparam logic [31:0] MTV  = 32'h0000_1007;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        csr_ena = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_idx = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_ilgl;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic        mret_valid = 1'b0;
  logic        instret = 1'b0;
  logic        ifu_csr_ren = 1'b0;
  logic [11:0] ifu_csr_idx = '0;
  logic [31:0] ifu_csr_rdata;
  logic        mstatus_mie;

  always #5 clock = ~clock;

  lieat_exu_com_csrfile #(.XLEN(XLEN), .CSR_IDX(12), .MTVEC_RST(MTV)) dut (
    .clock(clock), .reset(reset),
    .csr_ena(csr_ena), .csr_op(csr_op), .csr_idx(csr_idx), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ilgl(csr_ilgl),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_valid(mret_valid), .instret(instret),
    .ifu_csr_ren(ifu_csr_ren), .ifu_csr_idx(ifu_csr_idx), .ifu_csr_rdata(ifu_csr_rdata),
    .mstatus_mie(mstatus_mie)
  );

  int checks = 0;
  int errors = 0;

  // architectural state of the reference model
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
  logic [63:0] m_mcyc, m_minst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = MTV & ~32'h3;
    m_mepc = 0; m_mcause = 0; m_mscratch = 0;
    m_mcyc = 0; m_minst = 0;
  endtask

  function automatic logic [31:0] mread(input logic [11:0] a, output bit ok);
    logic [31:0] r;
    ok = 1;
    r  = 0;
    case (a)
      12'h300: r = 32'h1800 + (m_mpie ? 32'h80 : 0) + (m_mie ? 32'h8 : 0);
      12'h305: r = m_mtvec;
      12'h340: r = m_mscratch;
      12'h341: r = m_mepc;
      12'h342: r = m_mcause;
`ifdef LIEAT_CSR_COUNTER_EN
      12'hB00: r = m_mcyc[31:0];
      12'hB80: r = m_mcyc[63:32];
      12'hB02: r = m_minst[31:0];
      12'hB82: r = m_minst[63:32];
`endif
      default: ok = 0;
    endcase
    return r;
  endfunction

  task automatic compare();
    bit ok;
    logic [31:0] v, ifu_exp;
    v = mread(csr_idx, ok);
    ifu_exp = 0;
    if (!reset && ifu_csr_ren) begin
      if (ifu_csr_idx == 12'h305) ifu_exp = m_mtvec;
      else if (ifu_csr_idx == 12'h341) ifu_exp = m_mepc;
    end
    chk("csr_rdata", csr_rdata, (!reset && csr_ena && ok) ? v : 32'h0);
    chk("csr_ilgl", 32'(csr_ilgl), 32'(!reset && csr_ena && !ok));
    chk("ifu_csr_rdata", ifu_csr_rdata, ifu_exp);
    chk("mstatus_mie", 32'(mstatus_mie), 32'(m_mie));
  endtask

  task automatic model_update();
    bit ok, wc, wi;
    logic [31:0] old, nv;
    wc = 0; wi = 0;
    if (reset) begin
      model_reset();
      return;
    end
    old = mread(csr_idx, ok);
    if (trap_valid) begin
      m_mepc = trap_pc & ~32'h1;
      m_mcause = trap_cause;
      m_mpie = m_mie;
      m_mie = 0;
    end else if (mret_valid) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end else if (csr_ena && csr_op != 2'b00 && ok) begin
      if (csr_op == 2'b01)      nv = csr_wdata;
      else if (csr_op == 2'b10) nv = old | csr_wdata;
      else                      nv = old & ~csr_wdata;
      case (csr_idx)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h1;
        12'h342: m_mcause = nv;
`ifdef LIEAT_CSR_COUNTER_EN
        12'hB00: begin m_mcyc[31:0]   = nv; wc = 1; end
        12'hB80: begin m_mcyc[63:32]  = nv; wc = 1; end
        12'hB02: begin m_minst[31:0]  = nv; wi = 1; end
        12'hB82: begin m_minst[63:32] = nv; wi = 1; end
`endif
        default: ;
      endcase
    end
`ifdef LIEAT_CSR_COUNTER_EN
    if (!wc) m_mcyc = m_mcyc + 1;
    if (!wi && instret) m_minst = m_minst + 1;
`endif
  endtask

  task automatic sample();
    if (reset) model_reset();
    #1;
    compare();
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle();
    csr_ena = 0; csr_op = 0; csr_idx = 0; csr_wdata = 0;
    trap_valid = 0; trap_pc = 0; trap_cause = 0; mret_valid = 0;
    instret = 0; ifu_csr_ren = 0; ifu_csr_idx = 0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] idx, input logic [31:0] wd);
    idle();
    csr_ena = 1; csr_op = op; csr_idx = idx; csr_wdata = wd;
  endtask

  logic [11:0] addrs [12];

  initial begin
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0,
              12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h301, 12'h344};
    model_reset();
    idle();
    csr_ena = 1; csr_idx = 12'h300; ifu_csr_ren = 1; ifu_csr_idx = 12'h305;
    sample();
    chk("rst_csr_rdata", csr_rdata, 32'h0);
    chk("rst_ifu_rdata", ifu_csr_rdata, 32'h0);
    chk("rst_mie", 32'(mstatus_mie), 32'h0);
    advance();
    reset = 0;

    csr(2'b00, 12'h300, 0); sample();
    chk("mstatus_reset", csr_rdata, 32'h0000_1800);
    chk("ilgl_reset", 32'(csr_ilgl), 32'h0);
    advance();
    csr(2'b00, 12'h305, 0); sample();
    chk("mtvec_reset", csr_rdata, 32'h0000_1004);
    advance();

    csr(2'b01, 12'h305, 32'h8000_0103); sample(); advance();
    idle(); ifu_csr_ren = 1; ifu_csr_idx = 12'h305; sample();
    chk("ifu_mtvec", ifu_csr_rdata, 32'h8000_0100);
    advance();

    csr(2'b10, 12'h300, 32'h8); sample(); advance();
    csr(2'b00, 12'h300, 0);
    trap_valid = 1; trap_pc = 32'h8000_0011; trap_cause = 32'hB; sample();
    chk("mstatus_pre_trap", csr_rdata, 32'h0000_1808);
    advance();
    csr(2'b00, 12'h341, 0); ifu_csr_ren = 1; ifu_csr_idx = 12'h341; sample();
    chk("mepc_trap", csr_rdata, 32'h8000_0010);
    chk("ifu_mepc", ifu_csr_rdata, 32'h8000_0010);
    advance();
    csr(2'b00, 12'h342, 0); sample();
    chk("mcause_trap", csr_rdata, 32'hB);
    advance();
    csr(2'b00, 12'h300, 0); mret_valid = 1; sample();
    chk("mstatus_trap", csr_rdata, 32'h0000_1880);
    chk("mie_trap", 32'(mstatus_mie), 32'h0);
    advance();
    csr(2'b00, 12'h300, 0); sample();
    chk("mstatus_mret", csr_rdata, 32'h0000_1888);
    chk("mie_mret", 32'(mstatus_mie), 32'h1);
    advance();

    csr(2'b01, 12'h340, 32'h22); sample(); advance();
    csr(2'b01, 12'h340, 32'h55); trap_valid = 1; trap_pc = 32'h100; trap_cause = 32'h3; sample();
    chk("mscratch_old_on_trap", csr_rdata, 32'h22);
    advance();
    csr(2'b00, 12'h340, 0); sample();
    chk("mscratch_kept", csr_rdata, 32'h22);
    advance();
    csr(2'b00, 12'h342, 0); sample();
    chk("mcause_trap2", csr_rdata, 32'h3);
    advance();

    csr(2'b01, 12'h7C0, 32'hFFFF_FFFF); sample();
    chk("ilgl_7c0", 32'(csr_ilgl), 32'h1);
    chk("rdata_7c0", csr_rdata, 32'h0);
    advance();
`ifdef LIEAT_CSR_COUNTER_EN
    csr(2'b01, 12'hB00, 32'hFFFF_FFFE); sample(); advance();
    csr(2'b01, 12'hB80, 32'h0); sample(); advance();
    csr(2'b00, 12'hB00, 0); sample();
    chk("mcycle_held", csr_rdata, 32'hFFFF_FFFE);
    advance();
    csr(2'b00, 12'hB00, 0); sample();
    chk("mcycle_ones", csr_rdata, 32'hFFFF_FFFF);
    advance();
    csr(2'b00, 12'hB80, 0); sample();
    chk("mcycleh_carry", csr_rdata, 32'h1);
    advance();
    csr(2'b01, 12'hB02, 0); sample(); advance();
    for (int i = 0; i < 3; i++) begin
      idle(); instret = 1; sample(); advance();
    end
    csr(2'b00, 12'hB02, 0); sample();
    chk("minstret_3", csr_rdata, 32'h3);
    advance();
`else
    csr(2'b01, 12'hB00, 32'h1); sample();
    chk("ilgl_b00", 32'(csr_ilgl), 32'h1);
    advance();
`endif

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      csr_ena     = ($urandom_range(0, 3) != 0);
      csr_op      = 2'($urandom_range(0, 3));
      csr_idx     = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 11)];
      csr_wdata   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      trap_valid  = ($urandom_range(0, 15) == 0);
      trap_pc     = $urandom;
      trap_cause  = $urandom;
      mret_valid  = ($urandom_range(0, 11) == 0);
      instret     = 1'($urandom_range(0, 1));
      ifu_csr_ren = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ifu_csr_idx = 12'h305;
        1: ifu_csr_idx = 12'h341;
        2: ifu_csr_idx = 12'h300;
        default: ifu_csr_idx = 12'($urandom);
      endcase
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
